// File: rtl/sysid_reader_pkg.sv
// Shared types and constants for the system-ID reader: FSM state encoding,
// word offsets within the sysid control_slave, and the timeout counter width.
package sysid_reader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_REQ_ID  = 3'd1,
    ST_WAIT_ID = 3'd2,
    ST_REQ_TS  = 3'd3,
    ST_WAIT_TS = 3'd4,
    ST_FIN     = 3'd5
  } state_t;

  localparam logic [31:0] ID_OFFSET = 32'd0;
  localparam logic [31:0] TS_OFFSET = 32'd4;
  localparam int          CNT_W     = 16;

  // True in the states where a read phase is still outstanding.
  function automatic logic in_phase(input state_t s);
    return (s == ST_REQ_ID) || (s == ST_WAIT_ID) || (s == ST_REQ_TS) || (s == ST_WAIT_TS);
  endfunction

endpackage

// File: rtl/sysid_timeout_cnt.sv
// Per-transaction cycle counter for the system-ID reader.
// expired is asserted combinationally in the cycle where the count would step
// onto limit-1, so the phase leaves for FIN and FIN lands on cycle number
// 'limit' of the transaction (limit must be at least 2).
module sysid_timeout_cnt
  import sysid_reader_pkg::*;
(
  input  logic             clk,
  input  logic             reset_n,
  input  logic             clear,
  input  logic             enable,
  input  logic [CNT_W-1:0] limit,
  output logic             expired
);

  logic [CNT_W-1:0] count_reg;

  // Count cycles spent in the current phase; clearing takes priority.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_reg <= '0;
    end else if (clear) begin
      count_reg <= '0;
    end else if (enable) begin
      count_reg <= count_reg + CNT_W'(1);
    end
  end

  assign expired = enable && (count_reg == (limit - CNT_W'(2)));

endmodule

// File: rtl/sysid_reader.sv
// Avalon-MM master that reads the sysid ID and timestamp words and compares
// them against build-time values.
// Optional feature macro: SYSID_READER_AUTOSTART_EN issues one internal start
// pulse on the second clock edge after reset_n is released.
module sysid_reader
  import sysid_reader_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter logic [31:0] EXPECTED_ID = 32'h405D_AF4A,
  parameter logic [31:0] EXPECTED_TS = 32'h4E0B_6B1E,
  parameter int          TIMEOUT_CYC = 1024
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic        id_ok,
  output logic        ts_ok,
  output logic        timeout,
  output logic [31:0] id_value,
  output logic [31:0] ts_value,
  output logic [31:0] avm_address,
  output logic        avm_read,
  input  logic        avm_waitrequest,
  input  logic [31:0] avm_readdata,
  input  logic        avm_readdatavalid
);

  state_t state_reg, state_next;

  logic start_int;
  logic cnt_clear, cnt_en, cnt_expired;
  logic cap_id, cap_ts, set_timeout, clear_flags;
  logic [1:0] word_match;
  logic [1:0][31:0] expected_words;

`ifdef SYSID_READER_AUTOSTART_EN
  logic [1:0] auto_cnt_reg;

  // Walk 0 -> 1 -> 2 after reset; the value 1 is seen at the second edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      auto_cnt_reg <= 2'd0;
    end else if (auto_cnt_reg != 2'd2) begin
      auto_cnt_reg <= auto_cnt_reg + 2'd1;
    end
  end

  assign start_int = start | (auto_cnt_reg == 2'd1);
`else
  assign start_int = start;
`endif

  // Word 0 compares against the ID, word 1 against the timestamp.
  assign expected_words = {EXPECTED_TS, EXPECTED_ID};

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_match
      assign word_match[gi] = (avm_readdata == expected_words[gi]);
    end
  endgenerate

  sysid_timeout_cnt u_cnt (
    .clk     (clk),
    .reset_n (reset_n),
    .clear   (cnt_clear),
    .enable  (cnt_en),
    .limit   (CNT_W'(TIMEOUT_CYC)),
    .expired (cnt_expired)
  );

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state and per-cycle control; phase completion beats expiry.
  always_comb begin
    state_next  = state_reg;
    cnt_clear   = 1'b0;
    cnt_en      = in_phase(state_reg);
    cap_id      = 1'b0;
    cap_ts      = 1'b0;
    set_timeout = 1'b0;
    clear_flags = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (start_int) begin
          clear_flags = 1'b1;
          cnt_clear   = 1'b1;
          state_next  = ST_REQ_ID;
        end
      end
      ST_REQ_ID: begin
        if (!avm_waitrequest) begin
          state_next = ST_WAIT_ID;
        end else if (cnt_expired) begin
          set_timeout = 1'b1;
          state_next  = ST_FIN;
        end
      end
      ST_WAIT_ID: begin
        if (avm_readdatavalid) begin
          cap_id     = 1'b1;
          cnt_clear  = 1'b1;
          state_next = ST_REQ_TS;
        end else if (cnt_expired) begin
          set_timeout = 1'b1;
          state_next  = ST_FIN;
        end
      end
      ST_REQ_TS: begin
        if (!avm_waitrequest) begin
          state_next = ST_WAIT_TS;
        end else if (cnt_expired) begin
          set_timeout = 1'b1;
          state_next  = ST_FIN;
        end
      end
      ST_WAIT_TS: begin
        if (avm_readdatavalid) begin
          cap_ts     = 1'b1;
          state_next = ST_FIN;
        end else if (cnt_expired) begin
          set_timeout = 1'b1;
          state_next  = ST_FIN;
        end
      end
      ST_FIN: begin
        state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // Capture words and results; everything holds until the next accepted start.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      id_ok    <= 1'b0;
      ts_ok    <= 1'b0;
      timeout  <= 1'b0;
      id_value <= '0;
      ts_value <= '0;
    end else begin
      if (clear_flags) begin
        id_ok   <= 1'b0;
        ts_ok   <= 1'b0;
        timeout <= 1'b0;
      end
      if (cap_id) begin
        id_value <= avm_readdata;
        id_ok    <= word_match[0];
      end
      if (cap_ts) begin
        ts_value <= avm_readdata;
        ts_ok    <= word_match[1];
      end
      if (set_timeout) begin
        timeout <= 1'b1;
      end
    end
  end

  // Bus and status outputs decode straight from state so reset clears them at once.
  always_comb begin
    busy        = (state_reg != ST_IDLE);
    done        = (state_reg == ST_FIN);
    avm_read    = (state_reg == ST_REQ_ID) || (state_reg == ST_REQ_TS);
    avm_address = ((state_reg == ST_REQ_TS) || (state_reg == ST_WAIT_TS))
                  ? (BASE_ADDR + TS_OFFSET) : (BASE_ADDR + ID_OFFSET);
  end

endmodule

// File: tb/tb_sysid_reader.sv
// Scoreboard bench for sysid_reader: stimulus pushes expected results, a
// monitor pops and compares on each done pulse, a slave model answers reads.
module tb_sysid_reader;

  localparam logic [31:0] BASE   = 32'h0000_1000;
  localparam logic [31:0] EXP_ID = 32'h405D_AF4A;
  localparam logic [31:0] EXP_TS = 32'h4E0B_6B1E;
  localparam int          TMO    = 16;

  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic        start = 1'b0;
  logic        busy, done, id_ok, ts_ok, timeout, avm_read;
  logic [31:0] id_value, ts_value, avm_address;
  logic        avm_waitrequest = 1'b0;
  logic [31:0] avm_readdata = 32'h0;
  logic        avm_readdatavalid = 1'b0;

  sysid_reader #(
    .BASE_ADDR   (BASE),
    .EXPECTED_ID (EXP_ID),
    .EXPECTED_TS (EXP_TS),
    .TIMEOUT_CYC (TMO)
  ) dut (
    .clk               (clk),
    .reset_n           (reset_n),
    .start             (start),
    .busy              (busy),
    .done              (done),
    .id_ok             (id_ok),
    .ts_ok             (ts_ok),
    .timeout           (timeout),
    .id_value          (id_value),
    .ts_value          (ts_value),
    .avm_address       (avm_address),
    .avm_read          (avm_read),
    .avm_waitrequest   (avm_waitrequest),
    .avm_readdata      (avm_readdata),
    .avm_readdatavalid (avm_readdatavalid)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int tests = 0;
  int fails = 0;
  int done_cnt = 0;

  typedef struct {
    int          start_cyc;
    int          lat;
    logic        id_ok;
    logic        ts_ok;
    logic        tmo;
    logic [31:0] id_v;
    logic [31:0] ts_v;
  } exp_t;

  exp_t sb[$];

  // Slave model configuration and state.
  int          cfg_stall = 0;
  logic [31:0] cfg_w0 = EXP_ID;
  logic [31:0] cfg_w1 = EXP_TS;
  bit          cfg_drop_ts = 1'b0;
  bit          inject = 1'b0;
  logic [31:0] inject_data = 32'h0;
  bit          pend = 1'b0;
  logic [31:0] pend_addr = 32'h0;
  int          stall_left = 0;
  bit          stalled = 1'b0;
  logic [31:0] stalled_addr = 32'h0;

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask

  // Slave: latency-1 responder with programmable stall; also checks request stability.
  initial begin : slave
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        pend = 1'b0;
        stalled = 1'b0;
        avm_readdatavalid = 1'b0;
        avm_waitrequest = 1'b0;
        stall_left = cfg_stall;
      end else begin
        if (stalled) begin
          check32("stall_read_held", {31'b0, avm_read}, 32'd1);
          check32("stall_addr_held", avm_address, stalled_addr);
        end
        avm_readdatavalid = 1'b0;
        if (pend) begin
          pend = 1'b0;
          if (!(cfg_drop_ts && pend_addr == BASE + 32'd4)) begin
            avm_readdatavalid = 1'b1;
            avm_readdata = (pend_addr == BASE) ? cfg_w0 :
                           (pend_addr == BASE + 32'd4) ? cfg_w1 : 32'h0;
          end
        end else if (inject) begin
          inject = 1'b0;
          avm_readdatavalid = 1'b1;
          avm_readdata = inject_data;
        end
        stalled = 1'b0;
        if (avm_read) begin
          if (stall_left > 0) begin
            avm_waitrequest = 1'b1;
            stall_left--;
            stalled = 1'b1;
            stalled_addr = avm_address;
          end else begin
            avm_waitrequest = 1'b0;
            pend = 1'b1;
            pend_addr = avm_address;
            stall_left = cfg_stall;
          end
        end else begin
          avm_waitrequest = 1'b0;
          stall_left = cfg_stall;
        end
      end
    end
  end

  // Monitor: every done pulse is matched against the oldest expectation.
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (reset_n && done) begin
        done_cnt++;
        if (sb.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_done: got done at cycle %0d, want none", cyc);
        end else begin
          e = sb.pop_front();
          $display("[TB] check at cycle %0d: lat=%0d id=%h ts=%h id_ok=%0b ts_ok=%0b timeout=%0b",
                   cyc, cyc - e.start_cyc, id_value, ts_value, id_ok, ts_ok, timeout);
          check_int("done_latency", cyc - e.start_cyc, e.lat);
          check32("id_ok", {31'b0, id_ok}, {31'b0, e.id_ok});
          check32("ts_ok", {31'b0, ts_ok}, {31'b0, e.ts_ok});
          check32("timeout", {31'b0, timeout}, {31'b0, e.tmo});
          check32("id_value", id_value, e.id_v);
          check32("ts_value", ts_value, e.ts_v);
        end
      end
    end
  end

  task automatic issue_start(input bit push, input int lat, input logic eid, input logic ets,
                             input logic etmo, input logic [31:0] eidv, input logic [31:0] etsv);
    exp_t e;
    @(negedge clk);
    start = 1'b1;
    if (push) begin
      e.start_cyc = cyc;
      e.lat = lat;
      e.id_ok = eid;
      e.ts_ok = ets;
      e.tmo = etmo;
      e.id_v = eidv;
      e.ts_v = etsv;
      sb.push_back(e);
    end
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_drain(input int budget);
    int n = 0;
    while (sb.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      tests++;
      fails++;
      $display("FAIL drain_timeout: got %0d pending checks, want 0", sb.size());
      sb.delete();
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic check_cleared(input string tag);
    check32({tag, "_busy"}, {31'b0, busy}, 32'd0);
    check32({tag, "_done"}, {31'b0, done}, 32'd0);
    check32({tag, "_read"}, {31'b0, avm_read}, 32'd0);
    check32({tag, "_id_ok"}, {31'b0, id_ok}, 32'd0);
    check32({tag, "_ts_ok"}, {31'b0, ts_ok}, 32'd0);
    check32({tag, "_timeout"}, {31'b0, timeout}, 32'd0);
    check32({tag, "_id_value"}, id_value, 32'd0);
    check32({tag, "_ts_value"}, ts_value, 32'd0);
    check32({tag, "_address"}, avm_address, BASE);
  endtask

  initial begin : stim
    int d0;
    #2 reset_n = 1'b0;
    #1 check_cleared("reset");
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    // Nominal.
    issue_start(1, 5, 1'b1, 1'b1, 1'b0, EXP_ID, EXP_TS);
    wait_drain(100);

    // Timestamp mismatch.
    cfg_w1 = 32'h4E0B_6B1F;
    issue_start(1, 5, 1'b1, 1'b0, 1'b0, EXP_ID, 32'h4E0B_6B1F);
    wait_drain(100);

    // ID mismatch.
    cfg_w0 = 32'h405D_AF4B;
    cfg_w1 = EXP_TS;
    issue_start(1, 5, 1'b0, 1'b1, 1'b0, 32'h405D_AF4B, EXP_TS);
    wait_drain(100);

    // Seven-cycle stall on each request.
    cfg_w0 = EXP_ID;
    cfg_stall = 7;
    issue_start(1, 19, 1'b1, 1'b1, 1'b0, EXP_ID, EXP_TS);
    wait_drain(100);
    cfg_stall = 0;

    // Timestamp read never answered; value from the previous check holds.
    cfg_drop_ts = 1'b1;
    issue_start(1, 18, 1'b1, 1'b0, 1'b1, EXP_ID, EXP_TS);
    wait_drain(100);
    d0 = done_cnt;
    @(negedge clk);
    inject_data = 32'hDEAD_BEEF;
    inject = 1'b1;
    repeat (4) @(negedge clk);
    check32("late_rdv_ts_value", ts_value, EXP_TS);
    check32("late_rdv_ts_ok", {31'b0, ts_ok}, 32'd0);
    check32("late_rdv_timeout", {31'b0, timeout}, 32'd1);
    check32("late_rdv_busy", {31'b0, busy}, 32'd0);
    check_int("late_rdv_no_done", done_cnt - d0, 0);
    cfg_drop_ts = 1'b0;

    // Reset while waiting for word 0.
    issue_start(0, 0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    @(negedge clk);
    check32("pre_reset_busy", {31'b0, busy}, 32'd1);
    #2 reset_n = 1'b0;
    #1 check_cleared("midread_reset");
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
    issue_start(1, 5, 1'b1, 1'b1, 1'b0, EXP_ID, EXP_TS);
    wait_drain(100);

    // Start pulse during WAIT_TS is ignored.
    d0 = done_cnt;
    issue_start(1, 5, 1'b1, 1'b1, 1'b0, EXP_ID, EXP_TS);
    repeat (3) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_drain(100);
    repeat (15) @(negedge clk);
    check_int("busy_start_single_done", done_cnt - d0, 1);
    check32("busy_start_idle", {31'b0, busy}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got no finish, want finish before time limit");
    $fatal(1);
  end

endmodule
